// File: rtl/dense_result_streamer.sv
// Snapshots the dense y vector when resting rises, then streams it over valid/ready with a running argmax.
// m_valid follows the capture edge by one cycle and holds under stall; DENSE_STREAM_RELU_EN clamps negatives at capture.
module dense_result_streamer #(
  parameter int n  = 100,
  parameter int IW = $clog2(n)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [16*n-1:0] y,
  input  logic            resting,
  output logic [15:0]     m_data,
  output logic [IW-1:0]   m_index,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic [IW-1:0]   argmax_idx,
  output logic [15:0]     argmax_val,
  output logic            argmax_valid,
  output logic            overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state, state_nxt;
  logic                resting_q;
  logic                start;
  logic                hs;
  logic                at_last;
  logic [15:0]         cap [n];
  logic [15:0]         data_buf [n];
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic signed [15:0]  run_max;
  logic [IW-1:0]       run_idx;

  always_comb begin
    for (int j = 0; j < n; j++) begin
      cap[j] = y[16*j +: 16];
`ifdef DENSE_STREAM_RELU_EN
      if (y[16*j+15]) cap[j] = '0;
`endif
    end
  end

  assign start   = resting & ~resting_q;
  assign at_last = (idx == IW'(n-1));
  assign hs      = (state == STREAM) & m_ready;
  assign idx_nxt = idx + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (hs && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Snapshot storage is not reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) data_buf <= cap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resting_q    <= 1'b1;
      idx          <= '0;
      run_max      <= '0;
      run_idx      <= '0;
      argmax_idx   <= '0;
      argmax_val   <= '0;
      argmax_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      resting_q    <= resting;
      argmax_valid <= (state == DONE);
      if (start && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && start) begin
        idx     <= '0;
        run_max <= cap[0];
        run_idx <= '0;
      end else if (hs && !at_last) begin
        idx <= idx_nxt;
        // Strict compare so ties keep the earlier index.
        if ($signed(data_buf[idx_nxt]) > run_max) begin
          run_max <= data_buf[idx_nxt];
          run_idx <= idx_nxt;
        end
      end else if (state == DONE) begin
        argmax_idx <= run_idx;
        argmax_val <= run_max;
      end
    end
  end

  assign m_valid = (state == STREAM);
  assign m_data  = m_valid ? data_buf[idx] : '0;
  assign m_index = m_valid ? idx : '0;
  assign m_last  = m_valid & at_last;
  assign busy    = (state != IDLE);

endmodule
